// File: rtl/pr_skid_stage.sv
// Two-entry pipeline register slice with a skid buffer. in_ready_o depends only on registered
// state, so out_ready_i never reaches upstream combinationally.
module pr_skid_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               instr_valid_i,
    input  logic               rf_we_i,
    input  logic [RADDR_W-1:0] wr_i,
    input  logic [XLEN-1:0]    wd_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               instr_valid_o,
    output logic               rf_we_o,
    output logic [RADDR_W-1:0] wr_o,
    output logic [XLEN-1:0]    wd_o,
    output logic [1:0]         occ_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic               instr_valid;
        logic               rf_we;
        logic [RADDR_W-1:0] wr;
        logic [XLEN-1:0]    wd;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic   in_ready, out_valid, in_fire, out_fire;
    entry_t in_entry;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid_i & in_ready;
    assign out_fire  = out_valid & out_ready_i;

    assign in_entry = '{pc: pc_i, instr_valid: instr_valid_i, rf_we: rf_we_i, wr: wr_i, wd: wd_i};

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Payload is left stale; the valid-qualified outputs hide it.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid_i && !in_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready_o    = in_ready;
    assign out_valid_o   = out_valid;
    assign occ_o         = state_q;
    assign pc_o          = main_q.pc;
    assign wr_o          = main_q.wr;
    assign wd_o          = main_q.wd;
    assign rf_we_o       = main_q.rf_we & out_valid;
    assign instr_valid_o = main_q.instr_valid & out_valid;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/pr_skid_stage.md
PR_SKID_STAGE -- requirements
Module: pr_skid_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC and write-data width.
REQ-002 The block SHALL have parameter RADDR_W, default 5, meaning register-address width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 The block SHALL have port flush_i  input  1  synchronous flush of all held entries.
REQ-007 The block SHALL have port in_valid_i  input  1  upstream entry valid.
REQ-008 The block SHALL have port in_ready_o  output  1  block can accept an entry.
REQ-009 The block SHALL have ports pc_i (XLEN), instr_valid_i (1), rf_we_i (1), wr_i (RADDR_W), wd_i (XLEN)  input  upstream payload.
REQ-010 The block SHALL have port out_valid_o  output  1  downstream entry valid.
REQ-011 The block SHALL have port out_ready_i  input  1  downstream accepts entry.
REQ-012 The block SHALL have ports pc_o, instr_valid_o, rf_we_o, wr_o, wd_o  output  widths as inputs  downstream payload.
REQ-013 The block SHALL have port occ_o  output  2  entries held (0..2).
REQ-014 The block SHALL have port stall_cnt_o  output  CNT_W  saturating count of upstream-stall cycles.

Function
REQ-015 The block SHALL hold up to two entries: a main register (drives outputs) and a skid register.
REQ-016 The block SHALL define in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i.
REQ-017 The block SHALL implement states EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main and skid valid).
REQ-018 The block SHALL drive in_ready_o = (state != FULL) from registered state only, with no combinational path from out_ready_i.
REQ-019 The block SHALL drive out_valid_o = (state != EMPTY).
REQ-020 In EMPTY, the block SHALL, on in_fire, load main from inputs and go to ONE; otherwise it SHALL stay in EMPTY.
REQ-021 In ONE, the block SHALL, on in_fire & out_fire, load main from inputs and stay in ONE; on in_fire only, load skid and go to FULL; on out_fire only, go to EMPTY; otherwise hold.
REQ-022 In FULL, the block SHALL, on out_fire, copy skid to main and go to ONE; otherwise hold both entries unchanged.
REQ-023 The block SHALL give a latency of exactly 1 cycle from in_fire to out_valid_o when starting from EMPTY.
REQ-024 The block SHALL preserve entry order, with no entry dropped or duplicated.
REQ-025 The block SHALL drive rf_we_o = main.rf_we & out_valid_o and instr_valid_o = main.instr_valid & out_valid_o.
REQ-026 The block SHALL drive pc_o, wr_o and wd_o from main, holding their value while out_valid_o=1 & out_ready_i=0.
REQ-027 On flush_i=1, the block SHALL go to EMPTY at the next edge and discard any coincident in_fire, with flush taking priority over all transitions.
REQ-028 On flush_i=1, the block SHALL leave stale payload contents in place but keep them masked by REQ-025.
REQ-029 The block SHALL increment stall_cnt_o each cycle in which in_valid_i=1 & in_ready_o=0, saturating at 2^CNT_W-1, with no wrap.
REQ-030 The block SHALL NOT clear stall_cnt_o on flush_i; only reset clears it.
REQ-031 The block SHALL drive occ_o to match the state encoding of REQ-017 at all times.

Reset
REQ-032 While rst_n=0, the block SHALL force state EMPTY, with out_valid_o=0, occ_o=0, rf_we_o=0, instr_valid_o=0, pc_o=0, wr_o=0, wd_o=0, stall_cnt_o=0 and in_ready_o=1.
REQ-033 On rst_n assertion mid-operation (any state), the block SHALL immediately drop held entries and apply REQ-032 values without waiting for clk.
REQ-034 After rst_n deassertion, the block SHALL accept in_fire on the first rising edge.

Verification
REQ-035 The bench SHALL cover pass-through: out_ready_i=1, send pc=0x100 then 0x104 on back-to-back cycles -> out_valid_o on each following cycle with pc_o 0x100 then 0x104, occ_o=1, stall_cnt_o=0.
REQ-036 The bench SHALL cover backpressure fill: out_ready_i=0, send wd=0xA then 0xB -> occ_o=2, in_ready_o=0, wd_o=0xA held; a third in_valid_i held for 3 cycles -> stall_cnt_o=3.
REQ-037 The bench SHALL cover drain order: from FULL (0xA, 0xB), raise out_ready_i -> wd_o=0xA, then 0xB, then out_valid_o=0, occ_o 2->1->0.
REQ-038 The bench SHALL cover flush priority: in ONE with in_valid_i=1 and flush_i=1 -> next cycle occ_o=0, out_valid_o=0, rf_we_o=0, and the incoming entry never appears.
REQ-039 The bench SHALL cover async reset: rst_n low mid-cycle while FULL -> outputs at REQ-032 values before the next clk edge, and stall_cnt_o=0.
REQ-040 The bench SHALL cover saturation: CNT_W=2 with a permanent stall for 6 cycles -> stall_cnt_o sticks at 3.
